// File: rtl/timer_mmss.sv
// Three-digit BCD countdown timer (M:SS, 0:00-9:59) with keypad load, start/pause/cancel,
// door interlock and a one-cycle completion pulse. Define TIMER_AUTOCLEAR_EN for DONE auto-exit.
module timer_mmss #(
   parameter int DONE_TICKS = 3
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        tick,
   input  logic        load,
   input  logic [11:0] data,
   input  logic        start,
   input  logic        stop,
   input  logic        door_open,
   output logic [3:0]  min_out,
   output logic [3:0]  sec_tens_out,
   output logic [3:0]  sec_ones_out,
   output logic        running,
   output logic        done,
   output logic        zero,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t     st;
   logic [3:0] m, t, o;
   logic [3:0] dec_m, dec_t, dec_o;
   logic       dec_zero;
   logic [11:0] clean;

   if (DONE_TICKS < 1) begin : g_bad_done_ticks
      $error("DONE_TICKS must be at least 1");
   end

   // Each keypad field saturates on its own; an out-of-range digit never reaches the counters.
   always_comb begin
      clean[11:8] = (data[11:8] > 4'd9) ? 4'd9 : data[11:8];
      clean[7:4]  = (data[7:4]  > 4'd5) ? 4'd5 : data[7:4];
      clean[3:0]  = (data[3:0]  > 4'd9) ? 4'd9 : data[3:0];
   end

   // Whole borrow chain resolves here so 1:00 -> 0:59 lands in one edge.
   always_comb begin
      dec_o = o - 4'd1;
      dec_t = t;
      dec_m = m;
      if (o == 4'd0) begin
         dec_o = 4'd9;
         dec_t = t - 4'd1;
         if (t == 4'd0) begin
            dec_t = 4'd5;
            dec_m = m - 4'd1;
         end
      end
   end

   assign dec_zero     = (dec_m == 4'd0) && (dec_t == 4'd0) && (dec_o == 4'd0);
   assign zero         = (m == 4'd0) && (t == 4'd0) && (o == 4'd0);
   assign min_out      = m;
   assign sec_tens_out = t;
   assign sec_ones_out = o;
   assign state        = st;

`ifdef TIMER_AUTOCLEAR_EN
   localparam int CW = $clog2(DONE_TICKS + 1);
   logic [CW-1:0] done_cnt;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   // NOTE: reset is synchronous; clr is only seen on a rising clk edge.
   always_ff @(posedge clk) begin
      if (clr) begin
         st      <= IDLE;
         m       <= 4'd0;
         t       <= 4'd0;
         o       <= 4'd0;
         running <= 1'b0;
         done    <= 1'b0;
`ifdef TIMER_AUTOCLEAR_EN
         done_cnt <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (st)
            IDLE: begin
               if (stop) begin
                  m <= 4'd0;
                  t <= 4'd0;
                  o <= 4'd0;
               end else if (start && !door_open) begin
                  if (zero) begin
                     m <= 4'd0;
                     t <= 4'd3;
                     o <= 4'd0;
                  end
                  st      <= RUN;
                  running <= 1'b1;
               end else if (load) begin
                  {m, t, o} <= clean;
               end
            end
            RUN: begin
               if (door_open || stop) begin
                  st      <= PAUSE;
                  running <= 1'b0;
               end else if (tick) begin
                  m <= dec_m;
                  t <= dec_t;
                  o <= dec_o;
                  if (dec_zero) begin
                     st      <= DONE;
                     running <= 1'b0;
                     done    <= 1'b1;
`ifdef TIMER_AUTOCLEAR_EN
                     done_cnt <= '0;
`endif
                  end
               end
            end
            PAUSE: begin
               if (stop) begin
                  m  <= 4'd0;
                  t  <= 4'd0;
                  o  <= 4'd0;
                  st <= IDLE;
               end else if (start && !door_open) begin
                  if (zero) begin
                     st <= IDLE;
                  end else begin
                     st      <= RUN;
                     running <= 1'b1;
                  end
               end else if (load) begin
                  {m, t, o} <= clean;
               end
            end
            DONE: begin
               // The exiting command is consumed by the exit itself.
               if (start || stop || load) begin
                  st <= IDLE;
`ifdef TIMER_AUTOCLEAR_EN
               end else if (tick) begin
                  if (done_cnt == CW'(DONE_TICKS - 1)) st <= IDLE;
                  else done_cnt <= done_cnt + 1'b1;
`endif
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_timer_mmss.sv
// Scoreboarded bench for timer_mmss: expectations are queued as stimulus is driven and
// compared against the sampled outputs at the end of each scenario task.
module tb_timer_mmss;

   logic        clk = 1'b0;
   logic        clr, tick, load, start, stop, door_open;
   logic [11:0] data;
   logic [3:0]  min_out, sec_tens_out, sec_ones_out;
   logic        running, done, zero;
   logic [1:0]  state;

`ifdef TIMER_AUTOCLEAR_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_DONE = 2'd3;

   timer_mmss #(.DONE_TICKS(3)) dut (
      .clk(clk), .clr(clr), .tick(tick), .load(load), .data(data),
      .start(start), .stop(stop), .door_open(door_open),
      .min_out(min_out), .sec_tens_out(sec_tens_out), .sec_ones_out(sec_ones_out),
      .running(running), .done(done), .zero(zero), .state(state)
   );

   always #5 clk = ~clk;

   // {state, running, done, zero, min, sec_tens, sec_ones}
   logic [16:0] obs;
   assign obs = {state, running, done, zero, min_out, sec_tens_out, sec_ones_out};

   logic [16:0] exp_q[$];
   logic [16:0] got_q[$];
   string       name_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   function automatic logic [16:0] mk(input logic [1:0] st, input logic [3:0] mm,
                                      input logic [3:0] tt, input logic [3:0] oo,
                                      input logic dn);
      logic z;
      z = (mm == 4'd0) && (tt == 4'd0) && (oo == 4'd0);
      return {st, st == S_RUN, dn, z, mm, tt, oo};
   endfunction

   function automatic logic [16:0] mk_secs(input logic [1:0] st, input int s, input logic dn);
      return mk(st, 4'(s / 60), 4'((s % 60) / 10), 4'(s % 10), dn);
   endfunction

   task automatic step(input string nm, input logic c, input logic tk, input logic ld,
                       input logic [11:0] dt, input logic sa, input logic sp,
                       input logic dr, input logic [16:0] e);
      clr = c; tick = tk; load = ld; data = dt; start = sa; stop = sp; door_open = dr;
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(posedge clk);
      #1;
      got_q.push_back(obs);
      clr = 0; tick = 0; load = 0; data = '0; start = 0; stop = 0; door_open = 0;
   endtask

   task automatic test_reset;
      logic [16:0] e, g;
      string nm;
      step("reset1", 1, 0, 0, 12'h000, 0, 0, 0, mk(S_IDLE, 0, 0, 0, 0));
      step("reset2", 1, 0, 0, 12'h000, 0, 0, 0, mk(S_IDLE, 0, 0, 0, 0));
      step("load_07C", 0, 0, 1, 12'h07C, 0, 0, 0, mk(S_IDLE, 0, 5, 9, 0));
      step("load_FFF", 0, 0, 1, 12'hFFF, 0, 0, 0, mk(S_IDLE, 9, 5, 9, 0));
      step("load_5B3", 0, 0, 1, 12'h5B3, 0, 0, 0, mk(S_IDLE, 5, 5, 3, 0));
      step("idle_tick", 0, 1, 0, 12'h000, 0, 0, 0, mk(S_IDLE, 5, 5, 3, 0));
      step("start_5:53", 0, 0, 0, 12'h000, 1, 0, 0, mk(S_RUN, 5, 5, 3, 0));
      step("run_load_ign", 0, 0, 1, 12'h111, 0, 0, 0, mk(S_RUN, 5, 5, 3, 0));
      step("run_stop", 0, 0, 0, 12'h000, 0, 1, 0, mk(S_PAUSE, 5, 5, 3, 0));
      step("pause_tick_ign", 0, 1, 0, 12'h000, 0, 0, 0, mk(S_PAUSE, 5, 5, 3, 0));
      step("pause_load_0E4", 0, 0, 1, 12'h0E4, 0, 0, 0, mk(S_PAUSE, 0, 5, 4, 0));
      step("pause_load_0", 0, 0, 1, 12'h000, 0, 0, 0, mk(S_PAUSE, 0, 0, 0, 0));
      step("pause_start_zero", 0, 0, 0, 12'h000, 1, 0, 0, mk(S_IDLE, 0, 0, 0, 0));
      step("load_321", 0, 0, 1, 12'h321, 0, 0, 0, mk(S_IDLE, 3, 2, 1, 0));
      step("idle_stop_clear", 0, 0, 0, 12'h000, 0, 1, 0, mk(S_IDLE, 0, 0, 0, 0));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); nm = name_q.pop_front();
         n_cmp++;
         if (g !== e) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, g, e);
         end
      end
   endtask

   task automatic test_countdown;
      logic [16:0] e, g;
      string nm;
      int secs;
      step("load_102", 0, 0, 1, 12'h102, 0, 0, 0, mk(S_IDLE, 1, 0, 2, 0));
      step("start_102", 0, 0, 0, 12'h000, 1, 0, 0, mk(S_RUN, 1, 0, 2, 0));
      secs = 62;
      for (int i = 1; i <= 62; i++) begin
         secs--;
         step($sformatf("tick%0d", i), 0, 1, 0, 12'h000, 0, 0, 0,
              (secs == 0) ? mk_secs(S_DONE, 0, 1) : mk_secs(S_RUN, secs, 0));
      end
      step("done_hold", 0, 0, 0, 12'h000, 0, 0, 0, mk(S_DONE, 0, 0, 0, 0));
      for (int i = 1; i <= 10; i++)
         step($sformatf("done_tick%0d", i), 0, 1, 0, 12'h000, 0, 0, 0,
              mk((AUTO && i >= 3) ? S_IDLE : S_DONE, 0, 0, 0, 0));
      step("done_stop", 0, 0, 0, 12'h000, 0, 1, 0, mk(S_IDLE, 0, 0, 0, 0));
      step("load_001", 0, 0, 1, 12'h001, 0, 0, 0, mk(S_IDLE, 0, 0, 1, 0));
      step("start_001", 0, 0, 0, 12'h000, 1, 0, 0, mk(S_RUN, 0, 0, 1, 0));
      step("tick_to_done", 0, 1, 0, 12'h000, 0, 0, 0, mk(S_DONE, 0, 0, 0, 1));
      step("done_load_exit", 0, 0, 1, 12'h123, 0, 0, 0, mk(S_IDLE, 0, 0, 0, 0));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); nm = name_q.pop_front();
         n_cmp++;
         if (g !== e) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, g, e);
         end
      end
   endtask

   task automatic test_door;
      logic [16:0] e, g;
      string nm;
      step("load_010", 0, 0, 1, 12'h010, 0, 0, 0, mk(S_IDLE, 0, 1, 0, 0));
      step("start_010", 0, 0, 0, 12'h000, 1, 0, 0, mk(S_RUN, 0, 1, 0, 0));
      step("door_tick", 0, 1, 0, 12'h000, 0, 0, 1, mk(S_PAUSE, 0, 1, 0, 0));
      step("start_door_open", 0, 0, 0, 12'h000, 1, 0, 1, mk(S_PAUSE, 0, 1, 0, 0));
      step("resume", 0, 0, 0, 12'h000, 1, 0, 0, mk(S_RUN, 0, 1, 0, 0));
      step("tick_009", 0, 1, 0, 12'h000, 0, 0, 0, mk(S_RUN, 0, 0, 9, 0));
      step("stop_pause", 0, 0, 0, 12'h000, 0, 1, 0, mk(S_PAUSE, 0, 0, 9, 0));
      step("stop_cancel", 0, 0, 0, 12'h000, 0, 1, 0, mk(S_IDLE, 0, 0, 0, 0));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); nm = name_q.pop_front();
         n_cmp++;
         if (g !== e) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, g, e);
         end
      end
   endtask

   task automatic test_quickstart;
      logic [16:0] e, g;
      string nm;
      step("quick_start", 0, 0, 0, 12'h000, 1, 0, 0, mk(S_RUN, 0, 3, 0, 0));
      for (int i = 1; i <= 5; i++)
         step($sformatf("qs_tick%0d", i), 0, 1, 0, 12'h000, 0, 0, 0, mk_secs(S_RUN, 30 - i, 0));
      step("qs_stop1", 0, 0, 0, 12'h000, 0, 1, 0, mk(S_PAUSE, 0, 2, 5, 0));
      step("qs_stop2", 0, 0, 0, 12'h000, 0, 1, 0, mk(S_IDLE, 0, 0, 0, 0));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); nm = name_q.pop_front();
         n_cmp++;
         if (g !== e) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, g, e);
         end
      end
   endtask

   task automatic test_clr_midrun;
      logic [16:0] e, g;
      string nm;
      step("mr_load_001", 0, 0, 1, 12'h001, 0, 0, 0, mk(S_IDLE, 0, 0, 1, 0));
      step("mr_start", 0, 0, 0, 12'h000, 1, 0, 0, mk(S_RUN, 0, 0, 1, 0));
      step("mr_clr_tick", 1, 1, 0, 12'h000, 0, 0, 0, mk(S_IDLE, 0, 0, 0, 0));
      step("mr_after", 0, 1, 0, 12'h000, 0, 0, 0, mk(S_IDLE, 0, 0, 0, 0));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); nm = name_q.pop_front();
         n_cmp++;
         if (g !== e) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, g, e);
         end
      end
   endtask

   initial begin
      clr = 0; tick = 0; load = 0; data = '0; start = 0; stop = 0; door_open = 0;
      test_reset();
      test_countdown();
      test_door();
      test_quickstart();
      test_clr_midrun();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/timer_mmss.md
# timer_mmss

Three-digit BCD countdown timer (M:SS, 0:00–9:59) for the microwave controller. It chains a mod-10 seconds-ones digit, a mod-6 seconds-tens digit and a mod-10 minutes digit with borrow propagation. A control FSM handles keypad load, start/pause/cancel and door interlock, and flags completion. It consumes the 1 Hz tick from the prescaler and the BCD digits from keypad entry. It drives the display mux and the magnetron/lamp enable logic.

## Interface
- `DONE_TICKS`, default 3: ticks spent in DONE before auto-return to IDLE (used only with `TIMER_AUTOCLEAR_EN`).
- `clk` in 1: system clock, rising edge.
- `clr` in 1: reset; synchronous and active-high.
- `tick` in 1: 1 Hz enable, one `clk` wide.
- `load` in 1: load `data` into the digits.
- `data` in 12: BCD {minutes[11:8], sec_tens[7:4], sec_ones[3:0]}.
- `start` in 1: start/resume request.
- `stop` in 1: pause/cancel request.
- `door_open` in 1: door interlock; high means open.
- `min_out` out 4: minutes digit.
- `sec_tens_out` out 4: seconds tens digit.
- `sec_ones_out` out 4: seconds ones digit.
- `running` out 1: high in RUN (magnetron enable).
- `done` out 1: one-cycle completion pulse.
- `zero` out 1: all three digits equal 0.
- `state` out 2: IDLE=0, RUN=1, PAUSE=2, DONE=3.

## Operation
- Reset values: all digits 0, `state` IDLE, `running` 0, `done` 0, `zero` 1.
- Input priority per cycle: `clr` > `door_open` > `stop` > `start` > `load` > `tick`.
- Load sanitization: each field saturates independently.
  - sec_ones > 9 loads 9.
  - sec_tens > 5 loads 5.
  - minutes > 9 loads 9.
- IDLE:
  - `load`: digits take the sanitized `data`.
  - `start` with `!door_open` and `!zero`: go to RUN.
  - `start` with `!door_open` and `zero`: quick-start. Load 0:30 and go to RUN in the same edge.
  - `stop`: clear the digits to 0:00.
  - `tick`: ignored.
- RUN:
  - `door_open` or `stop`: go to PAUSE. A `tick` in the same cycle is discarded, with no decrement.
  - `tick`: decrement the value.
    - sec_ones 0 wraps to 9 and borrows.
    - sec_tens 0 wraps to 5 and borrows.
    - minutes decrements on borrow.
  - A tick at 0:01 produces 0:00 and moves to DONE.
  - `load` and `start`: ignored.
- PAUSE:
  - `start` with `!door_open`: resume in RUN. If `zero`, go to IDLE instead.
  - `stop`: clear the digits to 0:00 and go to IDLE (cancel).
  - `load`: digits take the sanitized `data`; stay in PAUSE.
  - `tick`: ignored.
- DONE:
  - Digits hold at 0:00.
  - `start`, `stop` or `load`: go to IDLE. The command itself is not executed in that cycle.
- `clr` in any state, including mid-RUN: next edge restores the reset values; the `done` pulse is suppressed.

## Timing
- All outputs are registered; no combinational path from input to output.
- Digits change on the same rising edge that samples `tick` high in RUN. A decrement is visible one cycle after the tick.
- `running` follows `state`: high exactly while `state`=RUN.
- `done` is high for exactly one cycle: the first cycle in DONE, when the digits read 0:00.
- `zero` is derived from the registered digits and stays consistent with them every cycle.
- Borrow across all digits (1:00 → 0:59) completes in a single edge.
- Back-to-back ticks on consecutive cycles each decrement once.

## Configuration
- `TIMER_AUTOCLEAR_EN` defined:
  - DONE counts `tick` pulses.
  - On the `DONE_TICKS`-th tick, go to IDLE automatically.
  - Explicit `start`/`stop`/`load` still exit early.
- Undefined: DONE persists until `start`, `stop`, `load` or `clr`. `DONE_TICKS` is unused.

## Test plan
- Reset and sanitized load:
  - Stimulus: `clr`=1 for 2 cycles, then `load` `data`=12'h0_7_C.
  - Response: outputs 0:00 and IDLE after reset, `zero`=1; after the load, digits show 0:59.
- Countdown with borrow and completion:
  - Stimulus: load 1:02, `start`, then 62 ticks.
  - Response: sequence passes 1:00 → 0:59; `done` pulses once on the 62nd tick's edge; `state`=3; `running`=0.
- Door interlock:
  - Stimulus: in RUN at 0:10, `door_open`=1 together with `tick`.
  - Response: PAUSE, digits stay 0:10. Then `start` with the door closed gives RUN; the next tick gives 0:09.
- Quick-start and cancel:
  - Stimulus: `start` in IDLE with 0:00; after 5 ticks, `stop` twice.
  - Response: after the ticks, 0:25 in RUN. First `stop` gives PAUSE at 0:25; second `stop` gives IDLE at 0:00.
- Reset mid-run:
  - Stimulus: `clr` while RUN at 0:01, same cycle as `tick`.
  - Response: IDLE, 0:00, `done` never asserted.
- Auto-clear (with `TIMER_AUTOCLEAR_EN`, `DONE_TICKS`=3):
  - Response: DONE exits to IDLE on the 3rd tick after completion.
  - Without the macro, the timer is still in DONE after 10 ticks.
